// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter.
// Holds widths, the drain FSM states and the pending entry.
package wb_port_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } pend_entry_t;

endpackage

// File: rtl/wb_pend_queue.sv
// Circular queue of pending long-latency writes.
// Entries carry a live bit cleared by a younger write to the same rd.
module wb_pend_queue
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  input  logic [REG_ADDR_W-1:0] q_rs1_i,
  input  logic [REG_ADDR_W-1:0] q_rs2_i,
  output pend_entry_t           head_o,
  output logic                  head_vld_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  q_rs1_busy_o,
  output logic                  q_rs2_busy_o
);

  localparam int PW = $clog2(DEPTH);

  pend_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW:0]      cnt_q;
  logic             push_live;
  logic             b1;
  logic             b2;

  // a result arriving with the same rd as a W write is born dead
  assign push_live = !(kill_i && (kill_rd_i == push_rd_i));

  // storage, pointers, kill broadcast and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && (mem_q[i].rd == kill_rd_i)) begin
          mem_q[i].live <= 1'b0;
        end
      end
      if (pop_i) begin
        vld_q[rd_ptr_q]      <= 1'b0;
        mem_q[rd_ptr_q].live <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + 1'b1;
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{live: push_live,
                             rd:   push_rd_i,
                             data: push_data_i};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(push_i)
                     - (PW+1)'(pop_i);
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign head_vld_o = vld_q[rd_ptr_q];
  assign count_o    = cnt_q;

  // rd match against live stored entries for hazard interlock
  always_comb begin
    b1 = 1'b0;
    b2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && mem_q[i].live) begin
        if (mem_q[i].rd == q_rs1_i) b1 = 1'b1;
        if (mem_q[i].rd == q_rs2_i) b2 = 1'b1;
      end
    end
    q_rs1_busy_o = b1 && (q_rs1_i != '0);
    q_rs2_busy_o = b2 && (q_rs2_i != '0);
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by W stage and long-latency unit.
// W always wins; starved queue heads force a one-cycle drain stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_wen,
  input  logic [REG_ADDR_W-1:0]  w_rd,
  input  logic [XLEN-1:0]        w_wdata,
  input  logic                   lu_valid,
  input  logic [REG_ADDR_W-1:0]  lu_rd,
  input  logic [XLEN-1:0]        lu_wdata,
  output logic                   lu_ready,
  output logic                   rf_wen,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   stall_req,
  input  logic [REG_ADDR_W-1:0]  q_rs1,
  input  logic [REG_ADDR_W-1:0]  q_rs2,
  output logic                   q_rs1_busy,
  output logic                   q_rs2_busy,
  output logic [$clog2(DEPTH):0] pend_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);

  arb_state_e  state_q;
  arb_state_e  state_d;
  logic [AW-1:0] age_q;
  logic [AW-1:0] age_d;
  pend_entry_t head;
  logic        head_vld;
  logic [CW-1:0] cnt;
  logic        w_write;
  logic        push;
  logic        pop;
  logic        head_write;
  logic        head_wait;

  assign w_write  = w_wen && (w_rd != '0);
  assign lu_ready = (cnt < CW'(DEPTH));
  assign push     = lu_valid && lu_ready && (lu_rd != '0);

  // a head killed by this cycle's W write leaves as a dead pop
  assign head_write = head_vld && head.live && !w_write;
  assign pop = head_vld &&
               (!head.live || !w_write || (head.rd == w_rd));
  assign head_wait = head_vld && !pop;

  wb_pend_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_rd_i    (lu_rd),
    .push_data_i  (lu_wdata),
    .pop_i        (pop),
    .kill_i       (w_write),
    .kill_rd_i    (w_rd),
    .q_rs1_i      (q_rs1),
    .q_rs2_i      (q_rs2),
    .head_o       (head),
    .head_vld_o   (head_vld),
    .count_o      (cnt),
    .q_rs1_busy_o (q_rs1_busy),
    .q_rs2_busy_o (q_rs2_busy)
  );

  assign pend_count = cnt;

  // W stage first, then a live queue head, otherwise idle
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_write) begin
      rf_wen   = 1'b1;
      rf_waddr = w_rd;
      rf_wdata = w_wdata;
    end else if (head_write) begin
      rf_wen   = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  // cycles the current head has been passed over, saturating
  always_comb begin
    age_d = '0;
    if (head_wait) begin
      if (age_q == AW'(MAX_WAIT)) age_d = age_q;
      else                        age_d = age_q + 1'b1;
    end
  end

  // drain FSM next state and stall request
  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    unique case (state_q)
      RUN: begin
        if (head_wait && (age_d == AW'(MAX_WAIT - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall_req = 1'b1;
        if (!head_wait) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // age and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed table, corner sequences,
// and random traffic against a queue-level reference model.
module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_wen;
  logic [4:0]  w_rd;
  logic [31:0] w_wdata;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_rs1_busy;
  logic        q_rs2_busy;
  logic [1:0]  pend_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_wen      (w_wen),
    .w_rd       (w_rd),
    .w_wdata    (w_wdata),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_rs1_busy (q_rs1_busy),
    .q_rs2_busy (q_rs2_busy),
    .pend_count (pend_count)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] lud;
    logic [4:0]  q1;
    logic [4:0]  q2;
  } in_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        ready;
    logic        b1;
    logic        b2;
    logic [1:0]  pend;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  vec_t  tbl[$];
  ment_t mq[$];
  int    m_wait;
  bit    m_drain;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic in_t I(bit wen, logic [4:0] wrd,
                            logic [31:0] wd, bit luv,
                            logic [4:0] lurd, logic [31:0] lud,
                            logic [4:0] q1, logic [4:0] q2);
    in_t v;
    v.wen = wen; v.wrd = wrd; v.wd = wd;
    v.luv = luv; v.lurd = lurd; v.lud = lud;
    v.q1 = q1; v.q2 = q2;
    return v;
  endfunction

  function automatic out_t O(bit wen, logic [4:0] addr,
                             logic [31:0] data, bit stall,
                             bit ready, bit b1, bit b2,
                             logic [1:0] pend);
    out_t o;
    o.wen = wen; o.addr = addr; o.data = data;
    o.stall = stall; o.ready = ready;
    o.b1 = b1; o.b2 = b2; o.pend = pend;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input out_t e);
    chk({tag, ".rf_wen"}, 32'(rf_wen), 32'(e.wen));
    if (e.wen) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
      chk({tag, ".rf_wdata"}, rf_wdata, e.data);
    end
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(e.stall));
    chk({tag, ".lu_ready"}, 32'(lu_ready), 32'(e.ready));
    chk({tag, ".q_rs1_busy"}, 32'(q_rs1_busy), 32'(e.b1));
    chk({tag, ".q_rs2_busy"}, 32'(q_rs2_busy), 32'(e.b2));
    chk({tag, ".pend_count"}, 32'(pend_count), 32'(e.pend));
  endtask

  task automatic drive(input in_t v);
    w_wen    = v.wen;
    w_rd     = v.wrd;
    w_wdata  = v.wd;
    lu_valid = v.luv;
    lu_rd    = v.lurd;
    lu_wdata = v.lud;
    q_rs1    = v.q1;
    q_rs2    = v.q2;
  endtask

  task automatic m_reset();
    mq.delete();
    m_wait  = 0;
    m_drain = 0;
  endtask

  // one cycle of the reference: outputs from current contents,
  // then advance the pending list past the clock edge
  task automatic m_step(input in_t v, output out_t e);
    bit ww;
    bit popped;
    bit waiting;
    ww = v.wen && (v.wrd != 0);
    e = O(0, 0, 0, m_drain, mq.size() < DEPTH, 0, 0,
          2'(mq.size()));
    foreach (mq[k]) begin
      if (mq[k].live && v.q1 != 0 && mq[k].rd == v.q1) e.b1 = 1;
      if (mq[k].live && v.q2 != 0 && mq[k].rd == v.q2) e.b2 = 1;
    end
    if (ww) begin
      foreach (mq[k]) if (mq[k].rd == v.wrd) mq[k].live = 0;
      e.wen = 1; e.addr = v.wrd; e.data = v.wd;
    end
    popped = 0;
    if (mq.size() > 0) begin
      if (!mq[0].live) begin
        popped = 1;
      end else if (!ww) begin
        popped = 1;
        e.wen = 1; e.addr = mq[0].rd; e.data = mq[0].data;
      end
    end
    waiting = (mq.size() > 0) && !popped;
    if (popped) void'(mq.pop_front());
    if (e.ready && v.luv && v.lurd != 0) begin
      ment_t n;
      n.rd = v.lurd;
      n.data = v.lud;
      n.live = !(ww && v.wrd == v.lurd);
      mq.push_back(n);
    end
    if (waiting) m_wait = (m_wait >= MAX_WAIT) ? MAX_WAIT
                                              : m_wait + 1;
    else         m_wait = 0;
    if (m_drain) m_drain = waiting;
    else         m_drain = waiting && (m_wait == MAX_WAIT - 1);
  endtask

  task automatic apply(input string tag, input in_t v,
                       output out_t e);
    @(negedge clk);
    drive(v);
    #1;
    m_step(v, e);
    cmp(tag, e);
    n_vec++;
  endtask

  in_t  v;
  out_t e;

  initial begin
    add(I(0,0,0, 1,5,'hDEAD, 5,0), O(0,0,0, 0,1,0,0,0));
    add(I(0,0,0, 0,0,0, 5,0), O(1,5,'hDEAD, 0,1,1,0,1));
    add(I(0,0,0, 0,0,0, 5,0), O(0,0,0, 0,1,0,0,0));
    add(I(1,1,'h100, 1,7,'h77, 7,0), O(1,1,'h100, 0,1,0,0,0));
    add(I(1,1,'h101, 0,0,0, 7,0), O(1,1,'h101, 0,1,1,0,1));
    add(I(1,2,'h102, 0,0,0, 7,0), O(1,2,'h102, 0,1,1,0,1));
    add(I(1,1,'h103, 0,0,0, 7,0), O(1,1,'h103, 0,1,1,0,1));
    add(I(0,0,0, 0,0,0, 7,0), O(1,7,'h77, 1,1,1,0,1));
    add(I(1,1,'h104, 0,0,0, 7,0), O(1,1,'h104, 0,1,0,0,0));
    add(I(1,1,'h200, 1,3,'h333, 3,0), O(1,1,'h200, 0,1,0,0,0));
    add(I(1,3,'h300, 0,0,0, 3,0), O(1,3,'h300, 0,1,1,0,1));
    add(I(0,0,0, 0,0,0, 3,0), O(0,0,0, 0,1,0,0,0));
    add(I(1,1,'h400, 1,4,'h44, 4,6), O(1,1,'h400, 0,1,0,0,0));
    add(I(1,2,'h401, 1,6,'h66, 4,6), O(1,2,'h401, 0,1,1,0,1));
    add(I(1,1,'h402, 1,8,'h88, 4,6), O(1,1,'h402, 0,0,1,1,2));
    add(I(0,0,0, 1,8,'h88, 4,6), O(1,4,'h44, 0,0,1,1,2));
    add(I(0,0,0, 1,8,'h88, 4,6), O(1,6,'h66, 0,1,0,1,1));
    add(I(0,0,0, 0,0,0, 4,8), O(1,8,'h88, 0,1,0,1,1));
    add(I(0,0,0, 0,0,0, 4,8), O(0,0,0, 0,1,0,0,0));
    add(I(1,0,'h55, 1,0,'h99, 0,0), O(0,0,0, 0,1,0,0,0));
    add(I(0,0,0, 0,0,0, 0,0), O(0,0,0, 0,1,0,0,0));

    rst_n = 1'b0;
    drive(I(0,0,0, 0,0,0, 5,5));
    m_reset();
    #3;
    cmp("reset", O(0,0,0, 0,1,0,0,0));
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      apply($sformatf("tbl%0d.model", k), tbl[k].i, e);
      cmp($sformatf("tbl%0d", k), tbl[k].o);
    end

    for (int c = 0; c < 4; c++) begin
      v = I(1, 1, 32'h500 + c, c < 2, (c == 0) ? 9 : 10,
            32'h900 + c, 9, 10);
      apply($sformatf("pre_rst%0d", c), v, e);
    end
    @(negedge clk);
    drive(I(0,0,0, 0,0,0, 9,10));
    #1;
    cmp("drain2", O(1,9,'h900, 1,0,1,1,2));
    n_vec++;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst", O(0,0,0, 0,1,0,0,0));
    n_vec++;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply($sformatf("post_rst%0d", c),
            I(0,0,0, 0,0,0, 9,10), e);
      chk($sformatf("post_rst%0d.quiet", c), 32'(rf_wen), 0);
    end

    for (int c = 0; c < 600; c++) begin
      v.wen  = m_drain ? ($urandom_range(0, 9) == 0)
                       : ($urandom_range(0, 3) != 0);
      v.wrd  = 5'($urandom_range(0, 3));
      v.wd   = $urandom;
      v.luv  = $urandom_range(0, 1) == 1;
      v.lurd = 5'($urandom_range(0, 3));
      v.lud  = $urandom;
      v.q1   = 5'($urandom_range(0, 3));
      v.q2   = 5'($urandom_range(0, 3));
      apply($sformatf("rnd%0d", c), v, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the W-stage writeback and a long-latency unit (divider/multiplier) result stream.
- W stage always has priority. Long-latency results are buffered in a small queue and written in idle write-port cycles.
- Forces a one-cycle pipeline stall when a buffered result has starved too long.
- Exports busy lookups for rs1/rs2 so hazard logic can interlock on pending results.

Parameters:
- XLEN, 32, data width of register writes.
- DEPTH, 2, pending-result queue entries (power of two, ≥2).
- MAX_WAIT, 4, cycles a queue head may wait before a forced drain (≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- w_wen  input  1  W-stage register write enable (RegWEn qualified by a valid instruction).
- w_rd  input  5  W-stage destination register.
- w_wdata  input  XLEN  W-stage writeback data (after WBSel mux).
- lu_valid  input  1  long-latency result valid.
- lu_rd  input  5  long-latency destination register.
- lu_wdata  input  XLEN  long-latency result.
- lu_ready  output  1  queue can accept a result.
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  XLEN  register-file write data.
- stall_req  output  1  freeze F/D/X and inject a bubble into W.
- q_rs1, q_rs2  input  5  hazard query addresses.
- q_rs1_busy, q_rs2_busy  output  1  query address has a pending queued write.
- pend_count  output  $clog2(DEPTH)+1  valid entries in the queue.

Behaviour:
- Reset (async, rst_n=0):
  - Queue emptied, age counter 0, FSM=RUN.
  - rf_wen=0, stall_req=0, lu_ready=1, pend_count=0, busy outputs 0.
  - Reset mid-operation discards pending results without any write.
- Accept rule:
  - lu_ready = (count < DEPTH), computed from current count only. A pop in the same cycle does not free a slot for a push.
  - A result is accepted when lu_valid && lu_ready.
  - lu_rd==0 is accepted and discarded, never enqueued.
- Write-port selection (combinational to rf_*):
  - If w_wen && w_rd!=0, write the W stage.
  - Else, if the queue head is valid-and-live, write the head and pop it.
  - Else rf_wen=0.
  - Writes to x0 never assert rf_wen.
- Latency: an accepted result can reach rf_wen no earlier than the next cycle (queue is registered).
- WAW kill:
  - When the W stage writes rd≠0, every queued entry with a matching rd is marked dead in that cycle. The W instruction is younger and supersedes them.
  - An incoming lu result accepted in the same cycle with a matching rd is enqueued dead.
  - Dead heads pop without a write, in any cycle, including cycles in which the W stage owns the port.
- Busy queries: qN_busy=1 iff qN≠0 and a live queued entry has rd==qN. The incoming lu_* is not included.
- Age counter:
  - Increments each cycle a live head is present and not popped.
  - Clears on pop or when the queue is empty.
  - Saturates at MAX_WAIT.
- FSM:
  - RUN: stall_req=0. Go to DRAIN when the live head is not popped this cycle and age==MAX_WAIT-1.
  - DRAIN: stall_req=1. The head pops this cycle because w_wen=0 is guaranteed by the bubble. Go to RUN after the pop.
  - If the queue is empty in DRAIN (only possible after a kill), go to RUN with no write.
  - w_wen=1 in DRAIN is a protocol violation: W still wins, and the FSM stays in DRAIN.
- pend_count counts live and dead entries and is registered.

Decomposition:
- Shared package holds:
  - XLEN and REG_ADDR_W=5 constants.
  - The FSM enum {RUN, DRAIN}.
  - The queue entry struct {live, rd, data}.
- Natural sub-module: wb_pend_queue, a circular FIFO with per-entry live bits, the kill-by-rd broadcast, and the busy match.
- The arbiter, age counter and FSM stay in wb_port_arbiter.

Test Plan:
- Idle W; lu result rd=5 data=0xDEAD accepted at cycle 0 → rf_wen=1, waddr=5, wdata=0xDEAD at cycle 1; pend_count 1→0.
- W writes every cycle; lu result rd=7 queued → rf_wen never selects the queue; stall_req=1 exactly MAX_WAIT(4) cycles after accept; bench drops w_wen; rd=7 written that cycle; stall_req=0 next cycle.
- Queue rd=3 live; W writes rd=3 → entry dead; q_rs1=3 busy goes 1→0; no later write to x3 with the lu data.
- Fill DEPTH=2 entries while W is busy → lu_ready=0; a pop cycle still keeps lu_ready=0 that cycle; it returns to 1 the next cycle.
- lu_rd=0 accepted → pend_count stays 0; rf_wen never asserts for it; W writes to x0 → rf_wen=0.
- rst_n asserted low mid-DRAIN with 2 entries → immediately stall_req=0, pend_count=0, lu_ready=1; no write after release.
